// File: rtl/dense_layer_backprop.sv
// Dense-layer backward pass: snapshots dy, x and w on start, then streams
// dW[i] = dy*x[i] and dX[i] = dy*w[i] one element per accepted beat.
module dense_layer_backprop #(
    parameter int N          = 64,
    parameter int DW         = 32,
    parameter int GRAD_SHIFT = 0,
    localparam int IW        = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] grad_out,
    input  logic signed [DW-1:0] input_x [0:N-1],
    input  logic signed [DW-1:0] weights [0:N-1],
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_idx,
    output logic signed [DW-1:0] grad_w,
    output logic signed [DW-1:0] grad_x,
    output logic                 out_last,
    output logic signed [DW-1:0] bias_grad,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic signed [DW-1:0]  dy_q, dy_d;
    logic signed [DW-1:0]  bias_q, bias_d;
    logic signed [DW-1:0]  x_q [N];
    logic signed [DW-1:0]  x_d [N];
    logic signed [DW-1:0]  w_q [N];
    logic signed [DW-1:0]  w_d [N];

    logic                  last_idx;
    logic signed [2*DW-1:0] prod_w, prod_x;

    assign last_idx = (idx_q == IW'(N - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dy_d    = dy_q;
        bias_d  = bias_q;
        x_d     = x_q;
        w_d     = w_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dy_d    = grad_out;
                    bias_d  = grad_out;
                    x_d     = input_x;
                    w_d     = weights;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (last_idx) state_d = DONE;
                    else          idx_d   = idx_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dy_q    <= '0;
            bias_q  <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dy_q    <= dy_d;
            bias_q  <= bias_d;
            x_q     <= x_d;
            w_q     <= w_d;
        end
    end

    // Full-width products, rescaled, then wrapped to DW bits.
    assign prod_w = (2*DW)'(dy_q) * (2*DW)'(x_q[idx_q]);
    assign prod_x = (2*DW)'(dy_q) * (2*DW)'(w_q[idx_q]);
    assign grad_w = DW'(prod_w >>> GRAD_SHIFT);
    assign grad_x = DW'(prod_x >>> GRAD_SHIFT);

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out_last  = out_valid && last_idx;
    assign out_idx   = idx_q;
    assign bias_grad = bias_q;

endmodule

// File: tb/tb_dense_layer_backprop.sv
// Bench for dense_layer_backprop: pass-level model checked every cycle,
// plus hand-computed literals for each directed scenario.
module tb_dense_layer_backprop;

    localparam int N  = 64;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [DW-1:0] grad_out;
    logic signed [DW-1:0] x [N];
    logic signed [DW-1:0] w [N];
    logic busy, out_valid, out_ready, out_last, done;
    logic [5:0] out_idx;
    logic signed [DW-1:0] grad_w, grad_x, bias_grad;

    logic start2;
    logic signed [DW-1:0] dy2;
    logic signed [DW-1:0] x2 [4];
    logic signed [DW-1:0] w2 [4];
    logic busy2, valid2, ready2, last2, done2;
    logic [1:0] idx2;
    logic signed [DW-1:0] gw2, gx2, bias2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dense_layer_backprop #(.N(N), .DW(DW), .GRAD_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .grad_out(grad_out),
        .input_x(x), .weights(w), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .grad_w(grad_w),
        .grad_x(grad_x), .out_last(out_last), .bias_grad(bias_grad),
        .done(done)
    );

    dense_layer_backprop #(.N(4), .DW(DW), .GRAD_SHIFT(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .grad_out(dy2),
        .input_x(x2), .weights(w2), .busy(busy2), .out_valid(valid2),
        .out_ready(ready2), .out_idx(idx2), .grad_w(gw2),
        .grad_x(gx2), .out_last(last2), .bias_grad(bias2),
        .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired @%0t", name, $time);
    endtask

    // Expected gradient: exact product, arithmetic shift, keep low DW bits.
    function automatic logic [31:0] gexp(input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input int sh);
        longint p;
        p = longint'(a) * longint'(b);
        p = p >>> sh;
        return p[31:0];
    endfunction

    // Pass-level model: what the stream must look like after the next edge.
    bit m_act, m_done;
    int m_idx;
    logic signed [31:0] m_dy, m_bias;
    logic signed [31:0] m_x [N];
    logic signed [31:0] m_w [N];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_bias", bias_grad, 0);
            chk("rst_gw", grad_w, 0);
            chk("rst_last", 32'(out_last), 0);
            m_act  = 0;
            m_done = 0;
            m_idx  = 0;
            m_dy   = 0;
            m_bias = 0;
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0;
                m_w[i] = 0;
            end
        end else begin
            chk("valid", 32'(out_valid), 32'(m_act));
            chk("busy", 32'(busy), 32'(m_act || m_done));
            chk("done", 32'(done), 32'(m_done));
            chk("bias", bias_grad, m_bias);
            if (m_act) begin
                chk("idx", 32'(out_idx), m_idx);
                chk("gw", grad_w, gexp(m_dy, m_x[m_idx], 0));
                chk("gx", grad_x, gexp(m_dy, m_w[m_idx], 0));
                chk("last", 32'(out_last), 32'(m_idx == N - 1));
            end
            if (m_done) begin
                m_done = 0;
            end else if (m_act) begin
                if (out_ready) begin
                    if (m_idx == N - 1) begin
                        m_act  = 0;
                        m_done = 1;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (start) begin
                m_dy   = grad_out;
                m_bias = grad_out;
                for (int i = 0; i < N; i++) begin
                    m_x[i] = x[i];
                    m_w[i] = w[i];
                end
                m_idx = 0;
                m_act = 1;
            end
        end
    end

    task automatic start_pass();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating.
    // hook 1: clobber inputs at idx 10; hook 2: pulse start at idx 10.
    task automatic run_stream(input int mode, input int hook,
                              input int lit_idx, input logic [31:0] lit_w,
                              input logic [31:0] lit_x,
                              output int nbeats, output int ndone);
        bit seen = 0;
        bit lit_ok = 0;
        nbeats = 0;
        ndone  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) nbeats++;
            if (out_valid && int'(out_idx) == lit_idx && !lit_ok) begin
                chk("lit_w", grad_w, lit_w);
                chk("lit_x", grad_x, lit_x);
                lit_ok = 1;
            end
            if (done) begin
                ndone++;
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            out_ready = (mode == 0) ? 1'b1 : ((cyc + 1) % 3 == 0);
            if (hook == 1 && out_valid && out_idx == 6'd10) begin
                grad_out = 100;
                for (int i = 0; i < N; i++) begin
                    x[i] = 7;
                    w[i] = 7;
                end
            end
            if (hook == 2) begin
                start = out_valid && out_idx == 6'd10;
                if (start) grad_out = 9;
            end
        end
        if (!seen) fail_now("done_timeout");
        if (!lit_ok) fail_now("lit_beat_missing");
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    int nb, nd;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        grad_out = '0;
        for (int i = 0; i < N; i++) begin
            x[i] = '0;
            w[i] = '0;
        end
        start2 = 1'b0;
        ready2 = 1'b0;
        dy2 = '0;
        for (int i = 0; i < 4; i++) begin
            x2[i] = '0;
            w2[i] = '0;
        end
        #2;
        chk("init_valid", 32'(out_valid), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_bias", bias_grad, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        grad_out = 3;
        for (int i = 0; i < N; i++) begin
            x[i] = i;
            w[i] = -i;
        end
        out_ready = 1'b1;
        start_pass();
        run_stream(0, 0, 5, 15, -15, nb, nd);
        chk("p1_beats", nb, 64);
        chk("p1_dones", nd, 1);
        chk("p1_bias", bias_grad, 3);

        out_ready = 1'b1;
        start_pass();
        run_stream(1, 0, 63, 189, -189, nb, nd);
        chk("bp_beats", nb, 64);
        chk("bp_dones", nd, 1);

        grad_out = 5;
        for (int i = 0; i < N; i++) begin
            x[i] = i + 1;
            w[i] = 2 * i;
        end
        out_ready = 1'b1;
        start_pass();
        run_stream(0, 1, 40, 205, 400, nb, nd);
        chk("snap_beats", nb, 64);
        chk("snap_bias", bias_grad, 5);

        grad_out = 3;
        for (int i = 0; i < N; i++) begin
            x[i] = i;
            w[i] = -i;
        end
        start_pass();
        run_stream(0, 2, 12, 36, -36, nb, nd);
        chk("ign_dones", nd, 1);
        chk("ign_bias", bias_grad, 3);
        chk("ign_busy", 32'(busy), 0);

        grad_out = 32'h40000000;
        x[0] = 32'h40000000;
        w[0] = 32'h00000001;
        x[1] = -1;
        start_pass();
        run_stream(0, 0, 0, 0, 32'h40000000, nb, nd);
        chk("ovf_dones", nd, 1);

        grad_out = 4;
        for (int i = 0; i < N; i++) begin
            x[i] = i;
            w[i] = i;
        end
        start_pass();
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (out_idx == 6'd20) break;
        end
        chk("abort_idx", 32'(out_idx), 20);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_bias", bias_grad, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_nodone", nd, 0);
        grad_out = -2;
        start_pass();
        run_stream(0, 0, 63, -126, -126, nb, nd);
        chk("post_beats", nb, 64);
        chk("post_dones", nd, 1);

        dy2 = 32'h00010000;
        x2[0] = -32'sh00008000;
        w2[0] = 32'h00030000;
        x2[1] = 32'h00018000;
        w2[1] = 32'h00020000;
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("s16_idx0", 32'(idx2), 0);
        chk("s16_gw0", gw2, 32'hFFFF8000);
        chk("s16_gx0", gx2, 32'h00030000);
        @(posedge clk); #1;
        ready2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s16_idx1", 32'(idx2), 1);
        chk("s16_gw1", gw2, 32'h00018000);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done2) begin
                nd = 1;
                break;
            end
        end
        if (nd == 0) fail_now("s16_done_timeout");
        chk("s16_bias", bias2, 32'h00010000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
